stdp_update_scheduler: RTL and testbench

Sequencer for STDP weight updates across NUM_PRE presynaptic synapses into one postsynaptic neuron. Tracks per-neuron spike timers, turns spike pairings inside the STDP window into LTP/LTD update requests, and arbitrates them round-robin onto a single shared weight-memory port. It sits between the spike sources and the synaptic weight store, as the only writer of that store.

---
 rtl/stdp_update_scheduler.sv | 147 ++++++++++++++
 tb/tb_stdp_update_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_update_scheduler.sv
// stdp_update_scheduler: spike timers, STDP pairing capture and round-robin weight update sequencer
module stdp_update_scheduler #(
  parameter int NUM_PRE = 4,
  parameter int TW = 8,
  parameter int WW = 4,
  parameter int WINDOW = 16,
  localparam int AW = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_PRE-1:0] pre_spike,
  input  logic               post_spike,
  output logic               mem_req,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [WW-1:0]      mem_wdata,
  input  logic               mem_ack,
  input  logic [WW-1:0]      mem_rdata,
  output logic               upd_valid,
  output logic [AW-1:0]      upd_addr,
  output logic               upd_ltp,
  output logic [WW-1:0]      upd_weight,
  output logic               overrun,
  output logic               busy
);
  localparam logic [TW-1:0] TMAX = '1;
  localparam logic [TW-1:0] WIN = TW'(WINDOW);
  localparam logic [TW-1:0] HALF = TW'(WINDOW / 2);
  typedef enum logic [1:0] {IDLE, READ, CALC, WRITE} state_t;
  state_t state, state_n;
  logic [TW-1:0] pre_timer [NUM_PRE];
  logic [TW-1:0] post_timer;
  logic [TW-1:0] pend_dt [NUM_PRE];
  logic [NUM_PRE-1:0] pend_v, pend_ltp, req, req_ltp, blocked, accept;
  logic [AW-1:0] rr_ptr, idx, sel, j;
  logic sel_found, commit;
  logic [WW-1:0] rdata, new_w;
  logic [WW:0] delta, sum, diff;
  assign mem_req = (state == READ) || (state == WRITE);
  assign mem_we = (state == WRITE);
  assign mem_addr = idx;
  assign busy = (|pend_v) || (state != IDLE);
  assign commit = (state == WRITE) && mem_ack;
  // Pairing detection against pre-update timers; a synapse spiking together with post is excluded
  always_comb begin
    req_ltp = '0;
    req = '0;
    blocked = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      req_ltp[i] = post_spike && !pre_spike[i] && (pre_timer[i] < WIN);
      req[i] = enable && (req_ltp[i] || (pre_spike[i] && !post_spike && (post_timer < WIN)));
      blocked[i] = pend_v[i] || ((state != IDLE) && (idx == AW'(i)));
    end
    accept = req & ~blocked;
  end
  // Round-robin pick: first valid slot at or after rr_ptr, scanning backwards so the nearest wins
  always_comb begin
    sel = '0;
    sel_found = 1'b0;
    j = '0;
    for (int k = NUM_PRE - 1; k >= 0; k--) begin
      j = AW'((int'(rr_ptr) + k) % NUM_PRE);
      if (pend_v[j]) begin
        sel = j;
        sel_found = 1'b1;
      end
    end
  end
  // Weight arithmetic at WW+1 bits so neither direction can wrap
  always_comb begin
    delta = (pend_dt[idx] < HALF) ? (WW+1)'(2) : (WW+1)'(1);
    sum = {1'b0, rdata} + delta;
    diff = {1'b0, rdata} - delta;
    new_w = pend_ltp[idx] ? (sum[WW] ? '1 : sum[WW-1:0]) : (diff[WW] ? '0 : diff[WW-1:0]);
  end
  // Next-state logic for the read-modify-write sequence
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = sel_found ? READ : IDLE;
      READ:    state_n = mem_ack ? CALC : READ;
      CALC:    state_n = WRITE;
      WRITE:   state_n = mem_ack ? IDLE : WRITE;
      default: state_n = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // Spike timers: load 0 on spike, otherwise count up and saturate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      post_timer <= TMAX;
      for (int i = 0; i < NUM_PRE; i++) pre_timer[i] <= TMAX;
    end else begin
      post_timer <= post_spike ? '0 : ((post_timer == TMAX) ? TMAX : post_timer + 1'b1);
      for (int i = 0; i < NUM_PRE; i++)
        pre_timer[i] <= pre_spike[i] ? '0 : ((pre_timer[i] == TMAX) ? TMAX : pre_timer[i] + 1'b1);
    end
  end
  // Pending slots: cleared on commit, filled by accepted requests, collisions flagged as overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_v <= '0;
      pend_ltp <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < NUM_PRE; i++) pend_dt[i] <= '0;
    end else begin
      overrun <= |(req & blocked);
      for (int i = 0; i < NUM_PRE; i++) begin
        if (commit && (idx == AW'(i))) pend_v[i] <= 1'b0;
        else if (accept[i]) begin
          pend_v[i] <= 1'b1;
          pend_ltp[i] <= req_ltp[i];
          pend_dt[i] <= req_ltp[i] ? pre_timer[i] : post_timer;
        end
      end
    end
  end
  // Datapath: latch index, read data, new weight, round-robin pointer and commit report
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      rdata <= '0;
      mem_wdata <= '0;
      rr_ptr <= '0;
      upd_valid <= 1'b0;
      upd_addr <= '0;
      upd_ltp <= 1'b0;
      upd_weight <= '0;
    end else begin
      upd_valid <= commit;
      if ((state == IDLE) && sel_found) idx <= sel;
      if ((state == READ) && mem_ack) rdata <= mem_rdata;
      if (state == CALC) mem_wdata <= new_w;
      if (commit) begin
        rr_ptr <= (idx == AW'(NUM_PRE - 1)) ? '0 : idx + 1'b1;
        upd_addr <= idx;
        upd_ltp <= pend_ltp[idx];
        upd_weight <= mem_wdata;
      end
    end
  end
endmodule

// File: tb/tb_stdp_update_scheduler.sv
// tb_stdp_update_scheduler: scoreboard bench with a behavioural weight memory
module tb_stdp_update_scheduler;
  localparam int N = 4;
  localparam int TW = 8;
  localparam int WW = 4;
  localparam int WINDOW = 16;
  typedef struct {int a; int ltp; int w;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic post_spike = 1'b0;
  logic [N-1:0] pre_spike = '0;
  logic mem_req, mem_we, mem_ack, upd_valid, upd_ltp, overrun, busy;
  logic [1:0] mem_addr, upd_addr;
  logic [WW-1:0] mem_wdata, mem_rdata, upd_weight;
  logic [WW-1:0] mem [N] = '{4'd8, 4'd5, 4'd0, 4'd15};
  int ew [N] = '{8, 5, 0, 15};
  exp_t sb[$];
  int passed = 0, total = 0;
  int ack_delay = 0, cnt = 0, n_rd = 0, n_wr = 0, n_upd = 0, n_push = 0, n_ovr = 0;
  bit hold_wr = 1'b0;
  logic prev_req = 1'b0, prev_we = 1'b0;
  logic [1:0] prev_addr = '0;
  logic [WW-1:0] prev_wdata = '0;

  always #5 clk = ~clk;

  stdp_update_scheduler #(.NUM_PRE(N), .TW(TW), .WW(WW), .WINDOW(WINDOW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pre_spike(pre_spike), .post_spike(post_spike),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .upd_valid(upd_valid), .upd_addr(upd_addr),
    .upd_ltp(upd_ltp), .upd_weight(upd_weight), .overrun(overrun), .busy(busy)
  );

  assign mem_ack = mem_req && (cnt == ack_delay) && !(hold_wr && mem_we);
  assign mem_rdata = mem[mem_addr];

  // Memory model with programmable wait states
  always @(posedge clk) begin
    cnt <= (!mem_req || mem_ack) ? 0 : cnt + 1;
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        n_wr <= n_wr + 1;
      end else n_rd <= n_rd + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int exp_w(int w, int ltp, int dt);
    int d = (dt < WINDOW / 2) ? 2 : 1;
    if (ltp != 0) return (w + d > (1 << WW) - 1) ? (1 << WW) - 1 : w + d;
    return (w < d) ? 0 : w - d;
  endfunction

  task automatic push(input int a, input int ltp, input int dt);
    exp_t e;
    e.a = a;
    e.ltp = ltp;
    e.w = exp_w(ew[a], ltp, dt);
    ew[a] = e.w;
    sb.push_back(e);
    n_push++;
  endtask

  // Scoreboard pop, overrun count and request-hold monitor
  always @(negedge clk) begin
    exp_t e;
    if (upd_valid) begin
      n_upd++;
      if (sb.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sb_addr", upd_addr, e.a);
        chk("sb_ltp", upd_ltp, e.ltp);
        chk("sb_weight", upd_weight, e.w);
      end
    end
    if (overrun) n_ovr++;
    if (mem_req && prev_req) begin
      chk("hold_addr", mem_addr, prev_addr);
      chk("hold_we", mem_we, prev_we);
      chk("hold_wdata", mem_wdata, prev_wdata);
    end
    prev_req = mem_req;
    prev_we = mem_we;
    prev_addr = mem_addr;
    prev_wdata = mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [N-1:0] pre, input logic post);
    pre_spike = pre;
    post_spike = post;
    tick();
    pre_spike = '0;
    post_spike = 1'b0;
  endtask

  task automatic settle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
    cycles(20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0;
    cycles(2);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_upd", {upd_valid, upd_addr, upd_ltp, upd_weight}, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    cycles(5);
    // LTP dt=2 on synapse 1 with exact zero-wait latency
    rd0 = n_rd;
    wr0 = n_wr;
    pulse(4'b0010, 1'b0);
    cycles(2);
    pulse(4'b0000, 1'b1);
    push(1, 1, 2);
    chk("t1_busy_k", busy, 1);
    chk("t1_req_k", mem_req, 0);
    tick();
    chk("t1_rd_req", mem_req, 1);
    chk("t1_rd_we", mem_we, 0);
    chk("t1_rd_addr", mem_addr, 1);
    tick();
    chk("t1_calc_req", mem_req, 0);
    tick();
    chk("t1_wr_req", mem_req, 1);
    chk("t1_wr_we", mem_we, 1);
    chk("t1_wr_addr", mem_addr, 1);
    chk("t1_wr_data", mem_wdata, 7);
    tick();
    chk("t1_upd_valid", upd_valid, 1);
    chk("t1_upd_addr", upd_addr, 1);
    chk("t1_upd_ltp", upd_ltp, 1);
    chk("t1_upd_weight", upd_weight, 7);
    chk("t1_busy_done", busy, 0);
    chk("t1_req_done", mem_req, 0);
    chk("t1_reads", n_rd - rd0, 1);
    chk("t1_writes", n_wr - wr0, 1);
    settle("t1_idle");
    // LTD dt=11 on synapse 2, weight 0 saturates at 0
    pulse(4'b0000, 1'b1);
    cycles(11);
    pulse(4'b0100, 1'b0);
    push(2, 0, 11);
    settle("t2_idle");
    chk("t2_mem", mem[2], 0);
    // Pre 20 cycles before post is outside the window
    rd0 = n_rd;
    pulse(4'b0001, 1'b0);
    cycles(19);
    pulse(4'b0000, 1'b1);
    cycles(8);
    chk("t3_busy", busy, 0);
    chk("t3_reads", n_rd - rd0, 0);
    settle("t3_idle");
    // Same-edge pre[0]+post excludes synapse 0; synapse 1 still pairs
    pulse(4'b0010, 1'b0);
    cycles(1);
    pulse(4'b0001, 1'b1);
    push(1, 1, 1);
    settle("t4_idle");
    // LTP of 2 on weight 15 saturates
    pulse(4'b1000, 1'b0);
    pulse(4'b0000, 1'b1);
    push(3, 1, 0);
    settle("t5_idle");
    chk("t5_mem", mem[3], 15);
    // All four pair at once: serviced 0,1,2,3
    pulse(4'b1111, 1'b0);
    cycles(2);
    pulse(4'b0000, 1'b1);
    for (int i = 0; i < N; i++) push(i, 1, 2);
    settle("t6_idle");
    // Pending {1,3} from rr_ptr=0: 1 then 3
    pulse(4'b1010, 1'b0);
    pulse(4'b0000, 1'b1);
    push(1, 1, 0);
    push(3, 1, 0);
    settle("t7_idle");
    // Overrun on synapse 3 with a 3-cycle memory wait
    ack_delay = 3;
    pulse(4'b0000, 1'b1);
    cycles(4);
    pulse(4'b1000, 1'b0);
    push(3, 0, 4);
    cycles(6);
    pulse(4'b1000, 1'b0);
    chk("t8_overrun_on", overrun, 1);
    tick();
    chk("t8_overrun_off", overrun, 0);
    settle("t8_idle");
    chk("t8_mem", mem[3], ew[3]);
    ack_delay = 0;
    // Reset while stalled in WRITE
    hold_wr = 1'b1;
    wr0 = n_wr;
    pulse(4'b0001, 1'b0);
    pulse(4'b0000, 1'b1);
    for (int n = 0; n < 20 && !mem_we; n++) tick();
    chk("t9_in_write", mem_we, 1);
    cycles(2);
    rst_n = 1'b0;
    tick();
    chk("t9_req", mem_req, 0);
    chk("t9_we", mem_we, 0);
    chk("t9_addr", mem_addr, 0);
    chk("t9_wdata", mem_wdata, 0);
    chk("t9_upd", {upd_valid, upd_addr, upd_ltp, upd_weight}, 0);
    chk("t9_overrun", overrun, 0);
    chk("t9_busy", busy, 0);
    chk("t9_post_timer", dut.post_timer, 255);
    for (int i = 0; i < N; i++) chk("t9_pre_timer", dut.pre_timer[i], 255);
    rst_n = 1'b1;
    hold_wr = 1'b0;
    rd0 = n_rd;
    pulse(4'b0000, 1'b1);
    cycles(6);
    chk("t9_post_busy", busy, 0);
    chk("t9_post_reads", n_rd - rd0, 0);
    chk("t9_no_write", n_wr - wr0, 0);
    chk("t9_mem", mem[0], ew[0]);
    cycles(2);
    chk("sb_empty", sb.size(), 0);
    chk("upd_count", n_upd, n_push);
    chk("overrun_count", n_ovr, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
